stuck_fault_bist: RTL

Parametrised built-in self-test controller for stuck-at fault detection. It drives every input vector of an N_IN-input combinational circuit-under-test (CUT) and compares a golden CUT instance against a fault-forced instance. It also drives the per-site force-enable and force-value lines that the faulty instance's injection muxes consume. It supports a single user-specified fault configuration, and an automatic sweep over every single stuck-at-0/1 fault that reports a coverage bitmap. It sits between the test host (start/result registers) and the pair of CUT instances.

---
 rtl/stuck_fault_bist_pkg.sv | 24 ++
 rtl/stuck_fault_bist_if.sv | 27 ++
 rtl/stuck_fault_bist_vec_gen.sv | 27 ++
 rtl/stuck_fault_bist.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/stuck_fault_bist_pkg.sv
// Shared constants for the stuck-at BIST controller: FSM state codes, run modes
// and the fault-index decoding helpers.
package fault_bist_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic {
        MODE_SINGLE = 1'b0,
        MODE_SWEEP  = 1'b1
    } mode_e;

    // Fault index f encodes (site, stuck value) as f = 2*site + value.
    function automatic int unsigned fault_site(input int unsigned f);
        return f >> 1;
    endfunction

    function automatic logic fault_val(input int unsigned f);
        return f[0];
    endfunction

endpackage

// File: rtl/stuck_fault_bist_if.sv
// Host-side register bundle of the BIST controller: run request, single-fault
// configuration and result readback.
interface bist_host_if #(
    parameter int N_IN    = 6,
    parameter int N_SITES = 4
);
    logic                   start;
    logic                   mode;
    logic [N_SITES-1:0]     fault_en_i;
    logic [N_SITES-1:0]     fault_val_i;
    logic                   busy;
    logic                   done;
    logic                   detected;
    logic [N_IN-1:0]        first_vec;
    logic [N_IN:0]          miss_cnt;
    logic [2*N_SITES-1:0]   coverage;

    modport master (
        output start, mode, fault_en_i, fault_val_i,
        input  busy, done, detected, first_vec, miss_cnt, coverage
    );

    modport slave (
        input  start, mode, fault_en_i, fault_val_i,
        output busy, done, detected, first_vec, miss_cnt, coverage
    );
endinterface

// File: rtl/stuck_fault_bist_vec_gen.sv
// Exhaustive test-vector counter; last_o flags the all-ones vector so the
// controller can end a fault without the counter ever wrapping.
module bist_vec_gen #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [N-1:0] vec_o,
    output logic         last_o
);
    logic [N-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= cnt_q + N'(1);
        end
    end

    assign vec_o  = cnt_q;
    assign last_o = &cnt_q;
endmodule

// File: rtl/stuck_fault_bist.sv
// Stuck-at fault BIST controller: sweeps all CUT input vectors, compares golden
// and fault-forced CUT outputs, and reports single-fault or sweep coverage.
module stuck_fault_bist
    import fault_bist_pkg::*;
#(
    parameter int N_IN    = 6,
    parameter int N_SITES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    bist_host_if.slave         host,
    input  logic               y_golden,
    input  logic               y_faulty,
    output logic [N_IN-1:0]    vec_o,
    output logic [N_SITES-1:0] force_en_o,
    output logic [N_SITES-1:0] force_val_o
);
    localparam int N_FAULTS = 2 * N_SITES;
    localparam int FW       = $clog2(N_FAULTS);
    localparam logic [FW-1:0] LAST_FAULT = FW'(N_FAULTS - 1);

    logic [1:0]            state_q,     state_d;
    mode_e                 mode_q,      mode_d;
    logic [FW-1:0]         fault_q,     fault_d;
    logic [N_SITES-1:0]    en_q,        en_d;
    logic [N_SITES-1:0]    val_q,       val_d;
    logic                  detected_q,  detected_d;
    logic [N_IN-1:0]       first_vec_q, first_vec_d;
    logic [N_IN:0]         miss_cnt_q,  miss_cnt_d;
    logic [N_FAULTS-1:0]   coverage_q,  coverage_d;

    logic [N_IN-1:0]    vec;
    logic               last_vec;
    logic               mismatch;
    logic               end_fault;
    logic [N_SITES-1:0] sweep_en;
    logic [N_SITES-1:0] sweep_val;
    logic [N_SITES-1:0] load_en;
    logic [N_SITES-1:0] load_val;

    bist_vec_gen #(.N(N_IN)) u_vec_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_RUN),
        .en_i   ((state_q == ST_RUN) && !end_fault),
        .vec_o  (vec),
        .last_o (last_vec)
    );

    // Sweep mode forces exactly one site, stuck at the low bit of the fault index.
    for (genvar gi = 0; gi < N_SITES; gi++) begin : g_sweep
        assign sweep_en[gi]  = (fault_site(32'(fault_q)) == gi);
        assign sweep_val[gi] = fault_val(32'(fault_q));
    end

    assign load_en   = (mode_q == MODE_SWEEP) ? sweep_en  : host.fault_en_i;
    assign load_val  = (mode_q == MODE_SWEEP) ? sweep_val : host.fault_val_i;
    assign mismatch  = y_golden ^ y_faulty;
    assign end_fault = last_vec || ((mode_q == MODE_SWEEP) && mismatch);

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        fault_d     = fault_q;
        en_d        = en_q;
        val_d       = val_q;
        detected_d  = detected_q;
        first_vec_d = first_vec_q;
        miss_cnt_d  = miss_cnt_q;
        coverage_d  = coverage_q;
        case (state_q)
            ST_IDLE: begin
                if (host.start) begin
                    state_d     = ST_LOAD;
                    mode_d      = mode_e'(host.mode);
                    fault_d     = '0;
                    detected_d  = 1'b0;
                    first_vec_d = '0;
                    miss_cnt_d  = '0;
                    coverage_d  = '0;
                end
            end
            ST_LOAD: begin
                en_d    = load_en;
                val_d   = load_val;
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (mismatch) begin
                    if (mode_q == MODE_SINGLE) begin
                        miss_cnt_d = miss_cnt_q + (N_IN+1)'(1);
                        if (!detected_q) begin
                            detected_d  = 1'b1;
                            first_vec_d = vec;
                        end
                    end else begin
                        coverage_d[fault_q] = 1'b1;
                    end
                end
                if (end_fault) begin
                    if ((mode_q == MODE_SINGLE) || (fault_q == LAST_FAULT)) begin
                        state_d = ST_DONE;
                    end else begin
                        fault_d = fault_q + FW'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_SINGLE;
            fault_q     <= '0;
            en_q        <= '0;
            val_q       <= '0;
            detected_q  <= 1'b0;
            first_vec_q <= '0;
            miss_cnt_q  <= '0;
            coverage_q  <= '0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            fault_q     <= fault_d;
            en_q        <= en_d;
            val_q       <= val_d;
            detected_q  <= detected_d;
            first_vec_q <= first_vec_d;
            miss_cnt_q  <= miss_cnt_d;
            coverage_q  <= coverage_d;
        end
    end

    // Forcing is decoded from state so reset releases it without waiting for a clock.
    always_comb begin
        force_en_o  = '0;
        force_val_o = '0;
        if (state_q == ST_LOAD) begin
            force_en_o  = load_en;
            force_val_o = load_val;
        end else if (state_q == ST_RUN) begin
            force_en_o  = en_q;
            force_val_o = val_q;
        end
    end

    assign vec_o          = vec;
    assign host.busy      = (state_q != ST_IDLE);
    assign host.done      = (state_q == ST_DONE);
    assign host.detected  = detected_q;
    assign host.first_vec = first_vec_q;
    assign host.miss_cnt  = miss_cnt_q;
    assign host.coverage  = coverage_q;
endmodule
